rr_stream_mux_4: RTL and testbench



---
 rtl/rr_stream_pkg.sv | 22 ++
 rtl/rr_stream_mux_4_if.sv | 26 ++
 rtl/mux_4_1.sv | 22 ++
 rtl/rr_grant_4.sv | 19 +
 rtl/rr_stream_mux_4.sv | 94 +++++++++
 tb/tb_rr_stream_mux_4.sv | 185 ++++++++++++++++++
 6 files changed

// File: rtl/rr_stream_pkg.sv
// Shared types and the rotating-priority pick used by the 4-source stream arbiter.
package rr_stream_pkg;

   localparam int N_SRC = 4;

   typedef logic [1:0] src_idx_t;

   typedef enum logic {EMPTY, FULL} state_t;

   // Returns {found, idx}: first valid source at or after ptr, wrapping mod 4.
   function automatic logic [2:0] rr_pick(input logic [N_SRC-1:0] valid, input src_idx_t ptr);
      logic [2:0] res;
      src_idx_t   cand;
      res = 3'b000;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = ptr + src_idx_t'(k);
         if (valid[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_stream_mux_4_if.sv
// Handshake bundle between four producers, the arbiter and one consumer.
interface rr_stream_mux_4_if #(parameter int W = 4);
   import rr_stream_pkg::*;

   logic [3:0]   in_valid;
   logic [W-1:0] in_data0;
   logic [W-1:0] in_data1;
   logic [W-1:0] in_data2;
   logic [W-1:0] in_data3;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   src_idx_t     out_sel;
   logic         out_ready;

   modport master (
      output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/mux_4_1.sv
// 4-bit 4:1 data mux driven by the arbiter's grant index.
module mux_4_1 (
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [1:0] sel,
   output logic [3:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0: y = d0;
         2'd1: y = d1;
         2'd2: y = d2;
         2'd3: y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/rr_grant_4.sv
// Combinational rotating-priority grant: first valid source starting at ptr.
module rr_grant_4
   import rr_stream_pkg::*;
(
   input  logic [3:0] in_valid,
   input  src_idx_t   ptr,
   output src_idx_t   grant,
   output logic       grant_valid
);

   logic [2:0] pick;

   always_comb begin
      pick        = rr_pick(in_valid, ptr);
      grant       = pick[1:0];
      grant_valid = |in_valid;
   end

endmodule

// File: rtl/rr_stream_mux_4.sv
// 4-input round-robin stream arbiter with a single registered output beat.
module rr_stream_mux_4
   import rr_stream_pkg::*;
#(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst,
   rr_stream_mux_4_if.slave bus
);

   state_t       state, state_nxt;
   src_idx_t     ptr;
   src_idx_t     grant;
   logic         grant_valid;
   logic         load;
   logic         accept;
   logic [W-1:0] mux_y;
   logic [W-1:0] data_p1;
   src_idx_t     sel_p1;
   logic [3:0]   ready;

   rr_grant_4 u_grant (
      .in_valid    (bus.in_valid),
      .ptr         (ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   generate
      if (W == 4) begin : g_mux_cell
         mux_4_1 u_mux (
            .d0  (bus.in_data0),
            .d1  (bus.in_data1),
            .d2  (bus.in_data2),
            .d3  (bus.in_data3),
            .sel (grant),
            .y   (mux_y)
         );
      end else begin : g_mux_beh
         always_comb begin
            mux_y = bus.in_data0;
            case (grant)
               2'd0: mux_y = bus.in_data0;
               2'd1: mux_y = bus.in_data1;
               2'd2: mux_y = bus.in_data2;
               2'd3: mux_y = bus.in_data3;
               default: mux_y = bus.in_data0;
            endcase
         end
      end
   endgenerate

   // Output register may take a new beat when empty or being popped this cycle.
   assign load   = (state == EMPTY) || bus.out_ready;
   assign accept = load && grant_valid && !rst;

   always_comb begin
      ready = 4'b0000;
      if (accept) ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (grant_valid) state_nxt = FULL;
         FULL:    if (bus.out_ready && !grant_valid) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // ---- p1: output beat register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         ptr     <= '0;
         data_p1 <= '0;
         sel_p1  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            data_p1 <= mux_y;
            sel_p1  <= grant;
            ptr     <= grant + 2'd1;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = data_p1;
   assign bus.out_sel   = sel_p1;

endmodule

// File: tb/tb_rr_stream_mux_4.sv
// Directed self-checking bench for the 4-input round-robin stream arbiter.
module tb_rr_stream_mux_4;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   rr_stream_mux_4_if #(.W(4)) bus ();

   rr_stream_mux_4 #(.W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 4'b0000;
      bus.out_ready = 1'b1;
      edge1();
      edge1();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         if (bus.in_ready !== 4'b0000) begin total_cnt++; $display("FAIL rst_in_ready: got %b expected 0000", bus.in_ready); end
         else begin total_cnt++; pass_cnt++; end
         edge1();
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
         chk("rst_out_data",  32'(bus.out_data),  32'd0);
      end
      rst = 1'b0;
      #1;
      chk("rst_first_ready", 32'(bus.in_ready), 32'b0001);
      edge1();
      chk("rst_first_sel",  32'(bus.out_sel),  32'd0);
      chk("rst_first_data", 32'(bus.out_data), 32'hA);
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_in_ready", 32'(bus.in_ready), 32'(4'b0001 << (k % 4)));
         edge1();
         chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
         chk("rr_out_sel",   32'(bus.out_sel),   32'(k % 4));
         chk("rr_out_data",  32'(bus.out_data),  32'(4'hA + (k % 4)));
      end
   endtask

   task automatic test_skip_idle();
      do_reset();
      bus.in_valid = 4'b0101;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("skip_in_ready", 32'(bus.in_ready), (k % 2 == 0) ? 32'b0001 : 32'b0100);
         edge1();
         chk("skip_out_sel", 32'(bus.out_sel), (k % 2 == 0) ? 32'd0 : 32'd2);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b0;
      #1;
      chk("bp_first_ready", 32'(bus.in_ready), 32'b0001);
      edge1();
      chk("bp_load_sel", 32'(bus.out_sel), 32'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_stall_ready", 32'(bus.in_ready), 32'b0000);
         edge1();
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_sel",   32'(bus.out_sel),   32'd0);
         chk("bp_hold_data",  32'(bus.out_data),  32'hA);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'b0010);
      edge1();
      chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_next_sel",   32'(bus.out_sel),   32'd1);
      chk("bp_next_data",  32'(bus.out_data),  32'hB);
   endtask

   task automatic test_drain();
      do_reset();
      bus.in_data3 = 4'h7;
      bus.in_valid = 4'b1000;
      bus.out_ready = 1'b1;
      #1;
      chk("drain_ready", 32'(bus.in_ready), 32'b1000);
      edge1();
      bus.in_valid = 4'b0000;
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_sel",   32'(bus.out_sel),   32'd3);
      chk("drain_data",  32'(bus.out_data),  32'h7);
      edge1();
      chk("drain_empty",     32'(bus.out_valid), 32'd0);
      chk("drain_keep_sel",  32'(bus.out_sel),   32'd3);
      chk("drain_keep_data", 32'(bus.out_data),  32'h7);
      bus.in_valid = 4'b1001;
      #1;
      chk("drain_wrap_ready", 32'(bus.in_ready), 32'b0001);
      edge1();
      chk("drain_wrap_sel", 32'(bus.out_sel), 32'd0);
      bus.in_data3 = 4'hD;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_valid = 4'b0010;
      bus.out_ready = 1'b0;
      edge1();
      chk("mid_held_valid", 32'(bus.out_valid), 32'd1);
      chk("mid_held_sel",   32'(bus.out_sel),   32'd1);
      bus.in_valid = 4'b1111;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(bus.in_ready), 32'b0000);
      edge1();
      rst = 1'b0;
      chk("mid_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_sel",   32'(bus.out_sel),   32'd0);
      chk("mid_data",  32'(bus.out_data),  32'd0);
      bus.out_ready = 1'b1;
      #1;
      chk("mid_ptr_ready", 32'(bus.in_ready), 32'b0001);
      edge1();
      chk("mid_new_sel",  32'(bus.out_sel),  32'd0);
      chk("mid_new_data", 32'(bus.out_data), 32'hA);
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 4'b0000;
      bus.in_data0 = 4'hA;
      bus.in_data1 = 4'hB;
      bus.in_data2 = 4'hC;
      bus.in_data3 = 4'hD;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_skip_idle();
      test_backpressure();
      test_drain();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
